// File: rtl/add_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package add_pkg;

    localparam int ADD_DW = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1) % n;
    endfunction

endpackage

// File: rtl/add_share_arbiter_if.sv
// Requester and result channels of the shared-adder arbiter.
// Latency: none (wiring only).
// Backpressure: req_ready per requester, res_ready on the result channel.
interface add_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic               res_valid;
    logic               res_ready;
    logic [DW-1:0]      res_sum;
    logic [IDW-1:0]     res_id;
    logic               busy;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_sum, res_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_sum, res_id, busy
    );
endinterface

// File: rtl/add_rr_pick.sv
// Round-robin pick: first valid requester at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; caller decides when the grant is consumed.
module add_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  grant,
    output logic            any_valid
);
    int idx;

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any_valid && req_valid[IDW'(idx)]) begin
                grant     = IDW'(idx);
                any_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/binary_adder.sv
// 4-bit modulo-16 adder; carry-out is dropped.
// Latency: combinational.
// Backpressure: none.
module binary_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/add_share_arbiter.sv
// Shares one binary_adder among NREQ requesters with round-robin grant.
// Latency: accept edge T -> res_valid after edge T+1; one result per 2 cycles peak.
// Backpressure: res_ready low holds the result and closes the accept window.
module add_share_arbiter
    import add_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int DW   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    add_share_arbiter_if.slave bus
);
    if (DW != ADD_DW) begin : g_dw_chk
        $error("add_share_arbiter: DW must equal ADD_DW");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
        $error("add_share_arbiter: NREQ must be 2..8");
    end

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  id_q;
    logic [DW-1:0]   op_a, op_b;
    logic [DW-1:0]   a_sel, b_sel;
    logic [DW-1:0]   sum;
    logic            res_valid_q;
    logic [DW-1:0]   res_sum_q;
    logic [IDW-1:0]  res_id_q;
    logic            busy_q;
    logic [IDW-1:0]  grant;
    logic            any_valid;
    logic            accept_win;
    logic            accept;
    logic [NREQ-1:0] req_ready_c;

    add_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req_valid (bus.req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .any_valid (any_valid)
    );

    binary_adder u_add (
        .a   (op_a),
        .b   (op_b),
        .sum (sum)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                a_sel = bus.req_a[i*DW +: DW];
                b_sel = bus.req_b[i*DW +: DW];
            end
        end
    end

    always_comb begin
        accept_win = 1'b0;
        state_d    = state_q;
        case (state_q)
            IDLE: accept_win = 1'b1;
            CALC: state_d    = DONE;
            DONE: accept_win = bus.res_ready;
            default: state_d = IDLE;
        endcase
        accept = accept_win && any_valid;
        if (state_q != CALC && accept_win) begin
            state_d = accept ? CALC : IDLE;
        end
    end

    // rst_n gates the strobe so nothing is accepted while reset is asserted.
    always_comb begin
        req_ready_c = '0;
        if (accept && rst_n) begin
            req_ready_c[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            op_a        <= '0;
            op_b        <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            if (accept) begin
                op_a  <= a_sel;
                op_b  <= b_sel;
                id_q  <= grant;
                ptr_q <= IDW'(rr_next(int'(grant), NREQ));
            end
            if (state_q == CALC) begin
                res_valid_q <= 1'b1;
                res_sum_q   <= sum;
                res_id_q    <= id_q;
            end else if (state_q == DONE && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed scoreboard bench for add_share_arbiter with NREQ=4.
module tb_add_share_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 4;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] sum;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    exp_t exp_q[$];

    add_share_arbiter_if #(.NREQ(NREQ), .DW(DW)) ifc ();

    add_share_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        ifc.req_valid[i]          = 1'b1;
        ifc.req_a[i*DW +: DW]     = 4'(a);
        ifc.req_b[i*DW +: DW]     = 4'(b);
    endtask

    task automatic clr_req(input int i);
        ifc.req_valid[i] = 1'b0;
    endtask

    task automatic push_exp(input int id, input int a, input int b);
        exp_t e;
        e.id  = 2'(id);
        e.sum = 4'((a + b) % 16);
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_sum"}, 32'(ifc.res_sum), 32'(e.sum));
            check({tag, "_id"},  32'(ifc.res_id),  32'(e.id));
        end
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (ifc.res_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_res_valid"}, 32'(ifc.res_valid), 1);
        if (ifc.res_valid === 1'b1) pop_cmp(tag);
    endtask

    task automatic do_one(input string tag, input int i, input int a, input int b);
        int n = 0;
        set_req(i, a, b);
        push_exp(i, a, b);
        #1;
        while (ifc.req_ready[i] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(ifc.req_ready), 32'(1 << i));
        tick();
        check({tag, "_ready_one_cycle"}, 32'(ifc.req_ready), 0);
        clr_req(i);
        wait_result(tag);
        check({tag, "_busy_done"}, 32'(ifc.busy), 1);
        ifc.res_ready = 1'b1;
        tick();
        check({tag, "_res_valid_drop"}, 32'(ifc.res_valid), 0);
        check({tag, "_busy_idle"}, 32'(ifc.busy), 0);
        ifc.res_ready = 1'b0;
    endtask

    initial begin
        int got;
        int last;
        n_chk         = 0;
        n_fail        = 0;
        ifc.req_valid = '0;
        ifc.req_a     = '0;
        ifc.req_b     = '0;
        ifc.res_ready = 1'b0;
        rst_n         = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_res_valid", 32'(ifc.res_valid), 0);
        check("rst_res_sum",   32'(ifc.res_sum),   0);
        check("rst_res_id",    32'(ifc.res_id),    0);
        check("rst_busy",      32'(ifc.busy),      0);
        check("rst_req_ready", 32'(ifc.req_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // single request and modulo-16 wrap on requester 1
        do_one("single", 0, 3, 4);
        do_one("wrap1", 1, 9, 8);
        do_one("wrap2", 1, 15, 15);
        do_one("wrap3", 1, 0, 0);

        // fairness: all four valid, consumer always ready
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, i + 5, 2 * i + 1);
        for (int k = 0; k < 6; k++) push_exp(k % 4, (k % 4) + 5, 2 * (k % 4) + 1);
        ifc.res_ready = 1'b1;
        #1;
        got  = 0;
        last = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            check("fair_onehot", 32'($countones(ifc.req_ready) <= 1), 1);
            if (ifc.res_valid === 1'b1) begin
                pop_cmp("fair");
                if (got > 0) check("fair_interval", 32'(c - last), 2);
                last = c;
                got++;
                if (got == 6) ifc.req_valid = '0;
            end
            if (got < 6) tick();
        end
        check("fair_count", 32'(got), 6);
        tick();
        ifc.res_ready = 1'b0;

        // backpressure: ptr is 2, requester 3 served, then held while 2 waits
        set_req(3, 10, 3);
        push_exp(3, 10, 3);
        #1;
        check("bp_ready3", 32'(ifc.req_ready), 32'h8);
        tick();
        clr_req(3);
        wait_result("bp_first");
        set_req(2, 6, 5);
        push_exp(2, 6, 5);
        #1;
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_valid", 32'(ifc.res_valid), 1);
            check("bp_hold_sum",   32'(ifc.res_sum),   13);
            check("bp_hold_id",    32'(ifc.res_id),    3);
            check("bp_hold_ready", 32'(ifc.req_ready), 0);
            tick();
        end
        ifc.res_ready = 1'b1;
        #1;
        check("bp_release_ready2", 32'(ifc.req_ready), 32'h4);
        tick();
        clr_req(2);
        wait_result("bp_second");
        tick();
        ifc.res_ready = 1'b0;

        // pointer wrap: ptr is 3, requesters 1 and 3 together
        set_req(1, 4, 4);
        set_req(3, 8, 9);
        push_exp(3, 8, 9);
        push_exp(1, 4, 4);
        #1;
        check("ptr_first3", 32'(ifc.req_ready), 32'h8);
        tick();
        clr_req(3);
        wait_result("ptr_r3");
        ifc.res_ready = 1'b1;
        #1;
        check("ptr_then1", 32'(ifc.req_ready), 32'h2);
        tick();
        clr_req(1);
        wait_result("ptr_r1");
        tick();
        ifc.res_ready = 1'b0;

        // async reset mid-CALC discards the transaction
        set_req(0, 1, 2);
        #1;
        check("ar_ready0", 32'(ifc.req_ready), 32'h1);
        tick();
        check("ar_busy_calc", 32'(ifc.busy), 1);
        rst_n = 1'b0;
        #1;
        check("ar_busy",      32'(ifc.busy),      0);
        check("ar_res_valid", 32'(ifc.res_valid), 0);
        check("ar_req_ready", 32'(ifc.req_ready), 0);
        clr_req(0);
        set_req(0, 2, 3);
        set_req(2, 5, 5);
        tick();
        rst_n = 1'b1;
        #1;
        check("ar_post_ready0", 32'(ifc.req_ready), 32'h1);
        push_exp(0, 2, 3);
        tick();
        clr_req(0);
        wait_result("ar_r0");
        ifc.res_ready = 1'b1;
        #1;
        check("ar_post_ready2", 32'(ifc.req_ready), 32'h4);
        push_exp(2, 5, 5);
        tick();
        clr_req(2);
        wait_result("ar_r2");
        tick();
        check("ar_end_busy", 32'(ifc.busy), 0);
        ifc.res_ready = 1'b0;
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
